fetch_pc_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 19 +
 rtl/pc_incrementer.sv | 13 +
 rtl/fetch_pc_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the RISC-V core front end.
package riscv_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_KILL = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Combinational sequential-PC adder; wraps modulo 2^XLEN.
module pc_incrementer
    import riscv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_plus4_o
);

    assign pc_plus4_o = pc_i + XLEN'(INSTR_BYTES);

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and single-outstanding instruction fetch sequencer feeding decode.
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            misalign_err
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_s;
    logic            req_valid_q, req_valid_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_pc4_q, if_pc4_d;
    logic            misalign_q, misalign_d;
    logic            redir_ok_s;
    logic            redir_bad_s;
    logic            req_accept_s;

    pc_incrementer #(.XLEN(XLEN)) u_pc_inc (
        .pc_i       (pc_q),
        .pc_plus4_o (pc_plus4_s)
    );

    assign redir_ok_s   = redirect_valid &&  is_word_aligned(redirect_target[1:0]);
    assign redir_bad_s  = redirect_valid && !is_word_aligned(redirect_target[1:0]);
    // Acceptance only counts once the registered valid is actually visible to memory.
    assign req_accept_s = req_valid_q && imem_req_ready;

    // Next-state, next-PC and decode-buffer update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        misalign_d = misalign_q | redir_bad_s;

        case (state_q)
            FETCH_REQ: begin
                if (redir_ok_s) begin
                    pc_d    = redirect_target;
                    state_d = req_accept_s ? FETCH_KILL : FETCH_REQ;
                end else if (req_accept_s) begin
                    state_d = FETCH_WAIT;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (redir_ok_s) begin
                    pc_d    = redirect_target;
                    state_d = imem_rsp_valid ? FETCH_REQ : FETCH_KILL;
                end else if (imem_rsp_valid) begin
                    instr_d  = imem_rsp_data;
                    if_pc_d  = pc_q;
                    if_pc4_d = pc_plus4_s;
                    pc_d     = pc_plus4_s;
                    state_d  = FETCH_HOLD;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_HOLD: begin
                if (redir_ok_s) begin
                    pc_d    = redirect_target;
                    state_d = FETCH_REQ;
                end else if (if_ready) begin
                    state_d = FETCH_REQ;
                end else begin
                    state_d = FETCH_HOLD;
                end
            end
            FETCH_KILL: begin
                if (redir_ok_s) begin
                    pc_d = redirect_target;
                end else begin
                    pc_d = pc_q;
                end
                state_d = imem_rsp_valid ? FETCH_REQ : FETCH_KILL;
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase

        req_valid_d = (state_d == FETCH_REQ);
        if_valid_d  = (state_d == FETCH_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_REQ;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            instr_q     <= 32'h0000_0000;
            if_pc_q     <= '0;
            if_pc4_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            if_valid_q  <= if_valid_d;
            instr_q     <= instr_d;
            if_pc_q     <= if_pc_d;
            if_pc4_q    <= if_pc4_d;
            misalign_q  <= misalign_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = instr_q;
    assign if_pc          = if_pc_q;
    assign if_pc_plus4    = if_pc4_q;
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a small variable-latency instruction memory.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misalign_err;

    int          total;
    int          bad;
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address 0 holds addi x1,x0,5; every other word reads as addr + 0x13.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0000) ? 32'h0050_0093 : (a + 32'h0000_0013);
    endfunction

    // Memory model: response mem_lat cycles after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt  <= 0;
            mem_addr <= 32'h0000_0000;
        end else if (imem_req_valid && imem_req_ready) begin
            mem_cnt  <= mem_lat;
            mem_addr <= imem_req_addr;
        end else if (mem_cnt != 0) begin
            mem_cnt  <= mem_cnt - 1;
        end
    end

    assign imem_rsp_valid = (mem_cnt == 1);
    assign imem_rsp_data  = (mem_cnt == 1) ? mem_word(mem_addr) : 32'h0000_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req_valid) break;
        end
        check({tag, "_valid"}, {31'd0, imem_req_valid}, 32'd1);
        check({tag, "_addr"}, imem_req_addr, exp_addr);
    endtask

    task automatic wait_if(input string tag, input logic [31:0] exp_instr,
                           input logic [31:0] exp_pc, input logic [31:0] exp_pc4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_valid) break;
        end
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, "_instr"}, if_instr, exp_instr);
        check({tag, "_pc"}, if_pc, exp_pc);
        check({tag, "_pc4"}, if_pc_plus4, exp_pc4);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        if_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0000_0000;
        mem_lat         = 1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'h0000_0000);
        check("rst_pc", if_pc, 32'h0000_0000);
        check("rst_pc4", if_pc_plus4, 32'h0000_0000);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        rst_n = 1'b1;

        // Basic sequential fetch
        wait_req("req0", 32'h0000_0000);
        wait_if("if0", 32'h0050_0093, 32'h0000_0000, 32'h0000_0004);
        wait_req("req1", 32'h0000_0004);

        // Decode backpressure for five cycles
        if_ready = 1'b0;
        wait_if("if1", 32'h0000_0017, 32'h0000_0004, 32'h0000_0008);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, if_valid}, 32'd1);
            check("bp_instr", if_instr, 32'h0000_0017);
            check("bp_pc", if_pc, 32'h0000_0004);
            check("bp_noreq", {31'd0, imem_req_valid}, 32'd0);
        end
        if_ready = 1'b1;
        wait_req("req2", 32'h0000_0008);

        // Redirect during WAIT with no response yet
        mem_lat = 2;
        @(negedge clk);
        check("wr_wait_ifv", {31'd0, if_valid}, 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h1000_0000;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("wr_kill_ifv", {31'd0, if_valid}, 32'd0);
        check("wr_kill_req", {31'd0, imem_req_valid}, 32'd0);
        mem_lat = 1;
        wait_req("wr_req", 32'h1000_0000);
        check("wr_req_ifv", {31'd0, if_valid}, 32'd0);
        wait_if("wr_if", 32'h1000_0013, 32'h1000_0000, 32'h1000_0004);

        // Redirect in the same cycle as the response
        wait_req("sr_req0", 32'h1000_0004);
        @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("sr_ifv", {31'd0, if_valid}, 32'd0);
        check("sr_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("sr_req_addr", imem_req_addr, 32'h0000_2000);
        if_ready = 1'b0;
        wait_if("sr_if", 32'h0000_2013, 32'h0000_2000, 32'h0000_2004);

        // Redirect in HOLD while decode is also ready
        if_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("hr_ifv", {31'd0, if_valid}, 32'd0);
        check("hr_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("hr_req_addr", imem_req_addr, 32'h0000_FFFC);
        wait_if("hr_if", 32'h0001_000F, 32'h0000_FFFC, 32'h0001_0000);
        wait_req("hr_req1", 32'h0001_0000);

        // Misaligned redirect in WAIT is ignored but flagged
        @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0006;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("ma_err", {31'd0, misalign_err}, 32'd1);
        check("ma_ifv", {31'd0, if_valid}, 32'd1);
        check("ma_pc", if_pc, 32'h0001_0000);
        check("ma_instr", if_instr, 32'h0001_0013);
        wait_req("ma_req", 32'h0001_0004);
        wait_if("ma_if", 32'h0001_0017, 32'h0001_0004, 32'h0001_0008);
        check("ma_sticky", {31'd0, misalign_err}, 32'd1);

        // Reset mid-operation clears everything
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst2_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst2_pc", if_pc, 32'h0000_0000);
        rst_n = 1'b1;

        // Redirect while REQ is stalled, then PC wrap
        wait_req("wp_req0", 32'h0000_0000);
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("wp_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("wp_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        wait_if("wp_if", 32'h0000_000F, 32'hFFFF_FFFC, 32'h0000_0000);
        wait_req("wp_req1", 32'h0000_0000);
        wait_if("wp_if1", 32'h0050_0093, 32'h0000_0000, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
